// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit.
//
// Multiplies with a shift-add loop and divides with a restoring loop. Each
// loop retires one bit per clock and works on operand magnitudes; the sign
// is applied once, when the last iteration completes. Divide-by-zero and
// signed-overflow divides need no iteration and finish one cycle after Start.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   Start      1-cycle request, accepted only in IDLE or DONE
//   MDControl  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   A, B       rs1 / rs2 operands, captured when Start is accepted
//   Result     registered result, held until the next result is written
//   Busy       high while iterating
//   Done       1-cycle pulse when Result is valid
//   Zero       Result == 0, registered with Result
//   Negative   Result MSB, registered with Result
//   DivByZero  divide/remainder with B == 0, registered with Result
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       MDControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic             Zero,
  output logic             Negative,
  output logic             DivByZero
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Iteration state. acc_q holds {hi, lo}: for multiply hi is the running
  // partial product and lo the not-yet-consumed multiplier bits; for divide
  // hi is the partial remainder and lo the dividend shifting into the quotient.
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_q;
  logic [CNT_W-1:0]   cnt_q;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    cond_neg_w = neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
    cond_neg_2w = neg ? -v : v;
  endfunction

  // Operand decode at the Start edge
  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    is_div, a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]        a_mag, b_mag;
  logic                    b_zero, sgn_ovf, special, accept;
  logic [WIDTH-1:0]        spec_res;

  always_comb begin
    a_s      = A;
    b_s      = B;
    is_div   = MDControl[2];
    a_signed = (MDControl == OP_MULH) || (MDControl == OP_MULHSU) ||
               (MDControl == OP_DIV)  || (MDControl == OP_REM);
    b_signed = (MDControl == OP_MULH) || (MDControl == OP_DIV) ||
               (MDControl == OP_REM);
    a_neg    = a_signed && (a_s < 0);
    b_neg    = b_signed && (b_s < 0);
    // -MOST_NEG wraps to MOST_NEG, which read unsigned is the right magnitude.
    a_mag    = cond_neg_w(A, a_neg);
    b_mag    = cond_neg_w(B, b_neg);
    b_zero   = (B == '0);
    sgn_ovf  = ((MDControl == OP_DIV) || (MDControl == OP_REM)) &&
               (A == MOST_NEG) && (B == '1);
    special  = is_div && (b_zero || sgn_ovf);
    accept   = Start && ((state == IDLE) || (state == DONE));
    // MDControl[1] separates REM/REMU from DIV/DIVU.
    spec_res = '0;
    if (b_zero) begin
      spec_res = MDControl[1] ? A : '1;
    end else begin
      spec_res = MDControl[1] ? '0 : A;
    end
  end

  // One iteration step and the finished result
  logic [WIDTH:0]       mul_sum, div_sh, div_trial;
  logic [2*WIDTH-1:0]   acc_nxt, mul_full;
  logic [WIDTH-1:0]     mul_res, div_res, fin_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    div_sh    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_trial = div_sh - {1'b0, opnd_q};
    if (op_q[2]) begin
      // Borrow set means the trial subtraction failed: restore by plain shift.
      if (div_trial[WIDTH]) begin
        acc_nxt = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    end

    mul_full = cond_neg_2w(acc_nxt, neg_q);
    mul_res  = (op_q == OP_MUL) ? mul_full[WIDTH-1:0] : mul_full[2*WIDTH-1:WIDTH];
    div_res  = op_q[1] ? cond_neg_w(acc_nxt[2*WIDTH-1:WIDTH], neg_q)
                       : cond_neg_w(acc_nxt[WIDTH-1:0], neg_q);
    fin_res  = op_q[2] ? div_res : mul_res;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_nxt = special ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (cnt_q == CNT_ONE) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      Result    <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Zero      <= 1'b1;
      Negative  <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        op_q   <= MDControl;
        opnd_q <= is_div ? b_mag : a_mag;
        acc_q  <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
        // Remainder follows the dividend; quotient and product follow both.
        neg_q  <= (is_div && MDControl[1]) ? a_neg : (a_neg ^ b_neg);
        cnt_q  <= CNT_LOAD;
        if (special) begin
          Result    <= spec_res;
          Zero      <= (spec_res == '0);
          Negative  <= spec_res[WIDTH-1];
          DivByZero <= b_zero;
          Busy      <= 1'b0;
          Done      <= 1'b1;
        end else begin
          Busy <= 1'b1;
        end
      end else if (state == CALC) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          Result    <= fin_res;
          Zero      <= (fin_res == '0);
          Negative  <= fin_res[WIDTH-1];
          DivByZero <= 1'b0;
          Busy      <= 1'b0;
          Done      <= 1'b1;
        end
      end
    end
  end

endmodule
